// File: rtl/bip_data_mem_arbiter.sv
// Two-port data memory arbiter: CPU port A and debug port B share one
// single-ported memory. Optional zero-fill after reset, then round-robin
// arbitration with combinational grants and one-cycle read latency.
module bip_data_mem_arbiter #(
  parameter int NB_DATA          = 16,
  parameter int N_ADDR           = 1024,
  parameter int LOG2_N_DATA_ADDR = 10,
  parameter int INIT_ON_RESET    = 1
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_a_req,
  input  logic                        i_a_wr,
  input  logic [LOG2_N_DATA_ADDR-1:0] i_a_addr,
  input  logic [NB_DATA-1:0]          i_a_data,
  input  logic                        i_b_req,
  input  logic                        i_b_wr,
  input  logic [LOG2_N_DATA_ADDR-1:0] i_b_addr,
  input  logic [NB_DATA-1:0]          i_b_data,
  output logic                        o_a_gnt,
  output logic                        o_b_gnt,
  output logic                        o_a_rvalid,
  output logic                        o_b_rvalid,
  output logic [NB_DATA-1:0]          o_a_rdata,
  output logic [NB_DATA-1:0]          o_b_rdata,
  output logic                        o_init_done,
  output logic [LOG2_N_DATA_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0]          o_mem_data,
  output logic                        o_mem_wr,
  output logic                        o_mem_rd,
  input  logic [NB_DATA-1:0]          i_mem_data
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam logic [LOG2_N_DATA_ADDR-1:0] LAST_ADDR = LOG2_N_DATA_ADDR'(N_ADDR - 1);
  localparam logic [LOG2_N_DATA_ADDR-1:0] ADDR_ONE  = LOG2_N_DATA_ADDR'(1);

  state_t                        state;
  logic [LOG2_N_DATA_ADDR-1:0]   init_addr;
  logic                          last_was_a;  // 0 = B granted most recently
  logic                          a_rvalid_q;
  logic                          b_rvalid_q;
  logic                          run;
  logic                          gnt_a;
  logic                          gnt_b;

  // Round-robin grant: a lone requester wins, contention goes to the port not granted last
  always_comb begin
    run   = (state == ST_RUN) && !i_reset;
    gnt_a = run && i_a_req && (!i_b_req || !last_was_a);
    gnt_b = run && i_b_req && (!i_a_req ||  last_was_a);
  end

  // Memory bus steering: fill pattern during INIT, otherwise the granted port
  always_comb begin
    o_mem_wr   = 1'b0;
    o_mem_rd   = 1'b0;
    o_mem_addr = '0;
    o_mem_data = '0;
    if (!i_reset && state == ST_INIT) begin
      o_mem_wr   = 1'b1;
      o_mem_addr = init_addr;
    end else if (gnt_a) begin
      o_mem_wr   = i_a_wr;
      o_mem_rd   = !i_a_wr;
      o_mem_addr = i_a_addr;
      o_mem_data = i_a_wr ? i_a_data : '0;
    end else if (gnt_b) begin
      o_mem_wr   = i_b_wr;
      o_mem_rd   = !i_b_wr;
      o_mem_addr = i_b_addr;
      o_mem_data = i_b_wr ? i_b_data : '0;
    end
  end

  // FSM, fill counter, round-robin pointer and read-valid pipeline
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      init_addr  <= '0;
      last_was_a <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          a_rvalid_q <= 1'b0;
          b_rvalid_q <= 1'b0;
          if (init_addr == LAST_ADDR) begin
            init_addr <= '0;
            state     <= ST_RUN;
          end else begin
            init_addr <= init_addr + ADDR_ONE;
          end
        end
        default: begin
          a_rvalid_q <= gnt_a && !i_a_wr;
          b_rvalid_q <= gnt_b && !i_b_wr;
          if (gnt_a) begin
            last_was_a <= 1'b1;
          end else if (gnt_b) begin
            last_was_a <= 1'b0;
          end
        end
      endcase
    end
  end

  // Gating with reset keeps a pending rvalid from escaping while reset is held
  always_comb begin
    o_a_gnt     = gnt_a;
    o_b_gnt     = gnt_b;
    o_a_rvalid  = a_rvalid_q && !i_reset;
    o_b_rvalid  = b_rvalid_q && !i_reset;
    o_a_rdata   = i_mem_data;
    o_b_rdata   = i_mem_data;
    o_init_done = run;
  end

endmodule

// File: tb/tb_bip_data_mem_arbiter.sv
// Bench for bip_data_mem_arbiter: directed scenarios then random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_bip_data_mem_arbiter;

  localparam int NB = 16;
  localparam int NA = 16;
  localparam int LA = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_wr, b_req, b_wr;
  logic [LA-1:0] a_addr, b_addr;
  logic [NB-1:0] a_data, b_data;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, init_done;
  logic [NB-1:0] a_rdata, b_rdata;
  logic [LA-1:0] mem_addr;
  logic [NB-1:0] mem_data, mem_q;
  logic          mem_wr, mem_rd;

  logic [NB-1:0] mem [NA];

  int tests = 0;
  int fails = 0;

  // reference model state
  bit            m_in_init;
  int            m_init_addr;
  bit            m_last_a;
  bit            m_pa, m_pb;
  logic [NB-1:0] m_pdata;
  logic [NB-1:0] m_mem [NA];
  bit            exp_ga, exp_gb;

  always #5 clk = ~clk;

  // behavioural memory with registered read
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_data;
    if (mem_rd) mem_q <= mem[mem_addr];
  end

  bip_data_mem_arbiter #(
    .NB_DATA(NB), .N_ADDR(NA), .LOG2_N_DATA_ADDR(LA), .INIT_ON_RESET(1)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_a_req(a_req), .i_a_wr(a_wr), .i_a_addr(a_addr), .i_a_data(a_data),
    .i_b_req(b_req), .i_b_wr(b_wr), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_a_gnt(a_gnt), .o_b_gnt(b_gnt),
    .o_a_rvalid(a_rvalid), .o_b_rvalid(b_rvalid),
    .o_a_rdata(a_rdata), .o_b_rdata(b_rdata),
    .o_init_done(init_done),
    .o_mem_addr(mem_addr), .o_mem_data(mem_data),
    .o_mem_wr(mem_wr), .o_mem_rd(mem_rd),
    .i_mem_data(mem_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs after the edge, check at the falling edge, advance the model
  task automatic cycle(input bit r,
                       input bit ar, input bit aw, input logic [LA-1:0] aa, input logic [NB-1:0] ad,
                       input bit br, input bit bw, input logic [LA-1:0] ba, input logic [NB-1:0] bd);
    bit            e_ga, e_gb, e_ra, e_rb, e_done, e_wr, e_rd;
    logic [LA-1:0] e_addr;
    logic [NB-1:0] e_data;
    @(posedge clk);
    #1;
    rst = r;
    a_req = ar; a_wr = aw; a_addr = aa; a_data = ad;
    b_req = br; b_wr = bw; b_addr = ba; b_data = bd;
    @(negedge clk);
    e_ga = 0; e_gb = 0; e_ra = 0; e_rb = 0; e_done = 0; e_wr = 0; e_rd = 0;
    e_addr = '0; e_data = '0;
    if (!r) begin
      if (m_in_init) begin
        e_wr   = 1;
        e_addr = LA'(m_init_addr);
      end else begin
        e_done = 1;
        e_ra   = m_pa;
        e_rb   = m_pb;
        if (ar && br) begin
          e_ga = !m_last_a;
          e_gb = m_last_a;
        end else begin
          e_ga = ar;
          e_gb = br;
        end
        if (e_ga) begin
          e_wr = aw; e_rd = !aw; e_addr = aa; e_data = aw ? ad : '0;
        end else if (e_gb) begin
          e_wr = bw; e_rd = !bw; e_addr = ba; e_data = bw ? bd : '0;
        end
      end
    end
    check("a_gnt", a_gnt, e_ga);
    check("b_gnt", b_gnt, e_gb);
    check("a_rvalid", a_rvalid, e_ra);
    check("b_rvalid", b_rvalid, e_rb);
    check("init_done", init_done, e_done);
    check("mem_wr", mem_wr, e_wr);
    check("mem_rd", mem_rd, e_rd);
    check("mem_addr", mem_addr, e_addr);
    check("mem_data", mem_data, e_data);
    if (e_ra) check("a_rdata", a_rdata, m_pdata);
    if (e_rb) check("b_rdata", b_rdata, m_pdata);
    check("wr_rd_exclusive", mem_wr && mem_rd, 0);
    check("gnt_before_init", (a_gnt || b_gnt) && !init_done, 0);
    // model update
    if (r) begin
      m_in_init = 1; m_init_addr = 0; m_last_a = 0; m_pa = 0; m_pb = 0;
    end else if (m_in_init) begin
      m_mem[m_init_addr] = '0;
      m_init_addr++;
      if (m_init_addr == NA) begin
        m_in_init = 0; m_init_addr = 0;
      end
      m_pa = 0; m_pb = 0;
    end else begin
      m_pa = e_ga && !aw;
      m_pb = e_gb && !bw;
      if (e_ga) begin
        if (aw) m_mem[aa] = ad; else m_pdata = m_mem[aa];
        m_last_a = 1;
      end else if (e_gb) begin
        if (bw) m_mem[ba] = bd; else m_pdata = m_mem[ba];
        m_last_a = 0;
      end
    end
    exp_ga = e_ga;
    exp_gb = e_gb;
  endtask

  task automatic idle(input bit r);
    cycle(r, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    bit            hr_a, hr_b, hw_a, hw_b;
    logic [LA-1:0] ha_a, ha_b;
    logic [NB-1:0] hd_a, hd_b;
    rst = 1; a_req = 0; a_wr = 0; a_addr = '0; a_data = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_data = '0;
    m_in_init = 1; m_init_addr = 0; m_last_a = 0; m_pa = 0; m_pb = 0; m_pdata = '0;

    idle(1);
    idle(1);
    check("reset_init_done", init_done, 0);

    // zero-fill: 16 writes of 0 to addresses 0..15
    for (int i = 0; i < NA; i++) begin
      idle(0);
      check("fill_wr", mem_wr, 1);
      check("fill_addr", mem_addr, i);
      check("fill_data", mem_data, 0);
    end
    cycle(0, 1, 0, 4'd9, '0, 0, 0, '0, '0);
    check("fill_done", init_done, 1);
    check("rd9_gnt", a_gnt, 1);
    idle(0);
    check("rd9_rvalid", a_rvalid, 1);
    check("rd9_rdata", a_rdata, 0);

    // A write then read back
    cycle(0, 1, 1, 4'd3, 16'h1234, 0, 0, '0, '0);
    check("wr3_gnt", a_gnt, 1);
    cycle(0, 1, 0, 4'd3, '0, 0, 0, '0, '0);
    check("rd3_gnt", a_gnt, 1);
    idle(0);
    check("rd3_rvalid", a_rvalid, 1);
    check("rd3_rdata", a_rdata, 16'h1234);

    // reset right after a read grant suppresses its rvalid
    cycle(0, 1, 0, 4'd3, '0, 0, 0, '0, '0);
    idle(1);
    check("rst_rvalid_suppressed", a_rvalid, 0);

    // reset in the middle of the fill restarts it from address 0
    for (int i = 0; i < 8; i++) idle(0);
    check("mid_fill_addr7", mem_addr, 7);
    idle(1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      idle(0);
      if (init_done) break;
      if (n == 0) check("refill_addr0", mem_addr, 0);
      n++;
    end
    check("refill_len", n, NA);

    // first contention after reset: A wins, B held and granted next
    cycle(0, 1, 0, 4'd5, '0, 1, 1, 4'd5, 16'h00AA);
    check("cont_a_gnt", a_gnt, 1);
    check("cont_b_wait", b_gnt, 0);
    cycle(0, 0, 0, '0, '0, 1, 1, 4'd5, 16'h00AA);
    check("cont_b_gnt", b_gnt, 1);
    check("cont_a_rdata", a_rdata, 0);
    cycle(0, 1, 0, 4'd5, '0, 0, 0, '0, '0);
    idle(0);
    check("cont_rd5_rdata", a_rdata, 16'h00AA);

    // continuous read contention: alternate A, B, A, B
    cycle(0, 0, 0, '0, '0, 1, 0, 4'd1, '0);
    idle(0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 4'd3, '0, 1, 0, 4'd5, '0);
      check("rr_a_gnt", a_gnt, (i % 2) == 0);
      check("rr_b_gnt", b_gnt, (i % 2) == 1);
    end
    idle(0);

    // random traffic; ungranted requests are held stable
    hr_a = 0; hr_b = 0; hw_a = 0; hw_b = 0; ha_a = '0; ha_b = '0; hd_a = '0; hd_b = '0;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 299) == 0);
      if (!(hr_a && !exp_ga)) begin
        hr_a = ($urandom_range(0, 2) != 0);
        hw_a = $urandom_range(0, 1);
        ha_a = LA'($urandom_range(0, NA - 1));
        hd_a = NB'($urandom);
      end
      if (!(hr_b && !exp_gb)) begin
        hr_b = ($urandom_range(0, 2) != 0);
        hw_b = $urandom_range(0, 1);
        ha_b = LA'($urandom_range(0, NA - 1));
        hd_b = NB'($urandom);
      end
      cycle(r, hr_a, hw_a, ha_a, hd_a, hr_b, hw_b, ha_b, hd_b);
    end
    idle(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
